// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-wide RAM port arbiter: access sizes, FSM states
// and transaction owners.
`timescale 1ns/1ps
package mem_arbiter_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_READ  = 2'b01,
    ARB_WRITE = 2'b10
  } arb_state_t;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_t;

  // Byte count of an access; the unused code 11 behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      MEM_BYTE: n = 3'd1;
      MEM_HALF: n = 3'd2;
      default:  n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single byte-wide RAM port between instruction fetch and MEM-stage
// loads/stores, serialising each access into little-endian byte cycles.
`timescale 1ns/1ps
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_done_out,
  output logic [31:0]       if_inst_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_wdata_in,
  input  logic [1:0]        mem_size_in,
  input  logic              mem_sext_in,
  output logic              mem_done_out,
  output logic [31:0]       mem_rdata_out,
  input  logic [7:0]        ram_din_in,
  output logic [7:0]        ram_dout_out,
  output logic [ADDR_W-1:0] ram_a_out,
  output logic              ram_wr_out,
  output logic              busy_out
);

  if (RAM_LAT != 1) begin : g_ram_lat_check
    $error("mem_arbiter: only RAM_LAT = 1 is supported");
  end

  arb_state_t        state_r;
  owner_t            owner_r;
  logic [ADDR_W-1:0] base_r;
  logic [2:0]        nbytes_r;
  logic [2:0]        cnt_r;
  logic [31:0]       wdata_r;
  logic [31:0]       asm_r;
  logic [1:0]        size_r;
  logic              sext_r;
  logic [ADDR_W-1:0] ram_a_r;
  logic [7:0]        ram_dout_r;
  logic              ram_wr_r;
  logic              if_done_r;
  logic              mem_done_r;
  logic [31:0]       if_inst_r;
  logic [31:0]       mem_rdata_r;

  logic [2:0]        cap_pos_s;
  logic [1:0]        cap_idx_s;
  logic [31:0]       asm_next_s;
  logic [31:0]       ext_s;
  logic [7:0]        wbyte_s;
  logic [ADDR_W-1:0] next_addr_s;

  // cnt_r holds the number of edges since acceptance; read data lags the address by two.
  always_comb begin
    cap_pos_s   = cnt_r - 3'd2;
    cap_idx_s   = cap_pos_s[1:0];
    asm_next_s  = asm_r;
    asm_next_s[{cap_idx_s, 3'b000} +: 8] = ram_din_in;
    wbyte_s     = wdata_r[{cnt_r[1:0], 3'b000} +: 8];
    next_addr_s = base_r + ADDR_W'(cnt_r);
  end

  // Load extension on the fully assembled value.
  always_comb begin
    ext_s = asm_next_s;
    case (size_r)
      MEM_BYTE: ext_s = sext_r ? {{24{asm_next_s[7]}}, asm_next_s[7:0]}
                               : {24'h000000, asm_next_s[7:0]};
      MEM_HALF: ext_s = sext_r ? {{16{asm_next_s[15]}}, asm_next_s[15:0]}
                               : {16'h0000, asm_next_s[15:0]};
      default:  ext_s = asm_next_s;
    endcase
  end

  // Arbitration and byte sequencing FSM; everything freezes while rdy_in is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r     <= ARB_IDLE;
      owner_r     <= OWNER_IF;
      base_r      <= '0;
      nbytes_r    <= 3'd0;
      cnt_r       <= 3'd0;
      wdata_r     <= 32'h0;
      asm_r       <= 32'h0;
      size_r      <= 2'b00;
      sext_r      <= 1'b0;
      ram_a_r     <= '0;
      ram_dout_r  <= 8'h00;
      ram_wr_r    <= 1'b0;
      if_done_r   <= 1'b0;
      mem_done_r  <= 1'b0;
      if_inst_r   <= 32'h0;
      mem_rdata_r <= 32'h0;
    end else if (rdy_in) begin
      if_done_r  <= 1'b0;
      mem_done_r <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          // A done pulse still high blocks acceptance so the requester can drop its req.
          if (!(if_done_r || mem_done_r)) begin
            if (mem_req_in) begin
              owner_r  <= OWNER_MEM;
              base_r   <= mem_addr_in;
              nbytes_r <= size_bytes(mem_size_in);
              wdata_r  <= mem_wdata_in;
              size_r   <= mem_size_in;
              sext_r   <= mem_sext_in;
              cnt_r    <= 3'd1;
              asm_r    <= 32'h0;
              ram_a_r  <= mem_addr_in;
              if (mem_we_in) begin
                state_r    <= ARB_WRITE;
                ram_dout_r <= mem_wdata_in[7:0];
                ram_wr_r   <= 1'b1;
              end else begin
                state_r <= ARB_READ;
              end
            end else if (if_req_in) begin
              owner_r  <= OWNER_IF;
              base_r   <= if_addr_in;
              nbytes_r <= 3'd4;
              size_r   <= MEM_WORD;
              sext_r   <= 1'b0;
              cnt_r    <= 3'd1;
              asm_r    <= 32'h0;
              ram_a_r  <= if_addr_in;
              state_r  <= ARB_READ;
            end
          end
        end
        ARB_READ: begin
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r < nbytes_r) begin
            ram_a_r <= next_addr_s;
          end
          if (cnt_r >= 3'd2) begin
            asm_r <= asm_next_s;
          end
          if (cnt_r == nbytes_r + 3'd1) begin
            state_r <= ARB_IDLE;
            if (owner_r == OWNER_IF) begin
              if_done_r <= 1'b1;
              if_inst_r <= asm_next_s;
            end else begin
              mem_done_r  <= 1'b1;
              mem_rdata_r <= ext_s;
            end
          end
        end
        ARB_WRITE: begin
          if (cnt_r < nbytes_r) begin
            ram_a_r    <= next_addr_s;
            ram_dout_r <= wbyte_s;
            cnt_r      <= cnt_r + 3'd1;
          end else begin
            ram_wr_r   <= 1'b0;
            mem_done_r <= 1'b1;
            state_r    <= ARB_IDLE;
          end
        end
        default: begin
          state_r  <= ARB_IDLE;
          ram_wr_r <= 1'b0;
        end
      endcase
    end
  end

  assign if_done_out   = if_done_r;
  assign if_inst_out   = if_inst_r;
  assign mem_done_out  = mem_done_r;
  assign mem_rdata_out = mem_rdata_r;
  assign ram_dout_out  = ram_dout_r;
  assign ram_a_out     = ram_a_r;
  assign ram_wr_out    = ram_wr_r & rdy_in;
  assign busy_out      = (state_r != ARB_IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Owns the single byte-wide RAM port and shares it between instruction fetch (IF) and the MEM stage's loads/stores driven by ex (load_out/store_out, mem_addr_out, mem_val_out).
- Serialises each 1/2/4-byte access into byte cycles, little-endian.
- Assembles read data and sign/zero-extends it for loads.
- Raises a one-cycle done pulse per transaction; the stall controller uses busy_out and the done pulses to hold the pipeline.

Parameters:
ADDR_W, 32, width of byte address on every address port
RAM_LAT, 1, fixed RAM read latency in cycles (only value 1 supported; elaboration error otherwise)

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  global ready; low = freeze
if_req_in  in  1  fetch request, held until if_done_out
if_addr_in  in  32  fetch byte address
if_done_out  out  1  one-cycle pulse: fetch complete
if_inst_out  out  32  fetched word, valid while if_done_out, held afterwards
mem_req_in  in  1  load/store request, held until mem_done_out
mem_we_in  in  1  1 = store, 0 = load
mem_addr_in  in  32  load/store byte address
mem_wdata_in  in  32  store data, low bytes used per size
mem_size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word
mem_sext_in  in  1  sign-extend load result (ignored for word)
mem_done_out  out  1  one-cycle pulse: load/store complete
mem_rdata_out  out  32  extended load data, valid while mem_done_out, held afterwards
ram_din_in  in  8  RAM read byte
ram_dout_out  out  8  RAM write byte
ram_a_out  out  32  RAM byte address
ram_wr_out  out  1  1 = write cycle
busy_out  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is asynchronous, active-high.
- Reset values: state = IDLE; every output 0; byte counter 0; assembly register 0.
- Reset mid-transaction:
  - Abort immediately; no done pulse.
  - Bytes already written stay in RAM.
- rdy_in low:
  - All registers hold, including state, counter, outputs and done pulses.
  - ram_wr_out is forced to 0 combinationally.
- FSM states: IDLE, RD, WR.
- Arbitration in IDLE (edge E0 = acceptance):
  - If mem_req_in is high, MEM wins, including when if_req_in is also high.
  - Otherwise if if_req_in is high, IF is served.
  - Latch owner, address, byte count n (1/2/4) and write data.
  - Go to RD, or to WR if MEM with mem_we_in = 1.
  - IF is always a 4-byte read.
  - No acceptance in the cycle a done pulse is high. This gives a 1-cycle bubble so the requester can drop its req.
- RD timing:
  - Byte address addr+i is registered onto ram_a_out at edge E0+i, for i = 0..n-1.
  - Byte i is captured from ram_din_in at edge E0+i+2 into bits [8i+7:8i].
  - At edge E0+n+1: the owner's done goes high with data, state returns to IDLE, and ram_a_out holds its last value.
- WR timing:
  - At edge E0+i (i = 0..n-1): ram_a_out = addr+i, ram_dout_out = wdata[8i+7:8i], ram_wr_out = 1.
  - At edge E0+n: ram_wr_out = 0, mem_done_out = 1, state returns to IDLE.
- Load extension:
  - Byte: sext ? {{24{b0[7]}}, b0} : {24'b0, b0}.
  - Half: same rule on bit 15.
  - Word: passed through.
- Address arithmetic: addr+i is computed modulo 2^32; wraps 0xFFFFFFFF to 0x00000000. Misaligned addresses are legal.
- Requests that drop mid-transaction are ignored; the transaction completes.
- done pulses last exactly one cycle. if_done_out and mem_done_out are never high together.

Decomposition:
- defines.v (shared header) gains: size codes MemByte/MemHalf/MemWord; FSM encodings ArbIdle/ArbRead/ArbWrite; owner codes OwnerIF/OwnerMEM.
- No sub-module. The extension logic is a local combinational block inside mem_arbiter.

Test Plan:
- IF fetch at 0x00000004, RAM bytes 13 05 00 00 → ram_a_out = 4,5,6,7 on consecutive cycles; if_done_out 5 edges after acceptance; if_inst_out = 0x00000513.
- MEM SW of 0xDEADBEEF to 0x100 → ram_wr_out high 4 cycles with EF,BE,AD,DE at 0x100..0x103; mem_done_out at E0+4.
- Simultaneous if_req_in and mem_req_in (LB, sext = 1, byte 0x80) → MEM served first, mem_rdata_out = 0xFFFFFF80; then 1 bubble cycle; then IF served.
- LHU at 0xFFFFFFFF with bytes 34 (at 0xFFFFFFFF) and 12 (at 0x0) → address wraps to 0; mem_rdata_out = 0x00001234.
- rdy_in low for 3 cycles mid-SW → no ram_wr_out during the pause, state held; done 3 cycles later than nominal.
- rst_in asserted at E0+2 of a word read → outputs 0 asynchronously, no done, busy_out = 0; a new request is accepted after release.
